// File: rtl/timer_if_pkg.sv
// Shared constants, FSM state type and bus command helpers for the
// interval-timer interrupt servicer.
package timer_if_pkg;

  localparam logic [2:0] TMR_ADDR_STATUS  = 3'd0;
  localparam logic [2:0] TMR_ADDR_CONTROL = 3'd1;

  localparam int unsigned STAT_TO  = 0;
  localparam int unsigned CTRL_ITO = 0;

  typedef enum logic [2:0] {
    IDLE,
    CFG_EN,
    WAIT_IRQ,
    RD_ADDR,
    RD_DATA,
    CLR,
    SETTLE,
    CFG_DIS
  } state_e;

  // One cycle's worth of Avalon initiator outputs.
  typedef struct packed {
    logic        cs;
    logic        write_n;
    logic [2:0]  addr;
    logic [15:0] wdata;
  } bus_cmd_t;

  function automatic bus_cmd_t bus_idle();
    bus_cmd_t c;
    c.cs      = 1'b0;
    c.write_n = 1'b1;
    c.addr    = '0;
    c.wdata   = '0;
    return c;
  endfunction

  function automatic bus_cmd_t bus_write(input logic [2:0] a, input logic [15:0] d);
    bus_cmd_t c;
    c.cs      = 1'b1;
    c.write_n = 1'b0;
    c.addr    = a;
    c.wdata   = d;
    return c;
  endfunction

  function automatic bus_cmd_t bus_read(input logic [2:0] a);
    bus_cmd_t c;
    c.cs      = 1'b1;
    c.write_n = 1'b1;
    c.addr    = a;
    c.wdata   = '0;
    return c;
  endfunction

endpackage

// File: rtl/timer_irq_servicer_if.sv
// Avalon-MM link between the servicer (master) and the interval timer (slave).
interface timer_irq_servicer_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/timer_irq_servicer.sv
// Hardware ISR for a 16-bit interval timer: enables its interrupt, services
// each timeout by reading status and clearing the TO flag, and publishes a
// tick counter/pulse plus a saturating count of spurious interrupts.
module timer_irq_servicer
  import timer_if_pkg::*;
#(
  parameter int unsigned TICK_W = 32,
  parameter int unsigned SPUR_W = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 irq_in,
  timer_irq_servicer_if.master bus,
  output logic [TICK_W-1:0]    tick_count,
  output logic                 tick_pulse,
  output logic [SPUR_W-1:0]    spurious_count,
  output logic                 busy
);

  state_e              state_q, state_d;
  bus_cmd_t            cmd_q, cmd_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic                pulse_q, pulse_d;
  logic [SPUR_W-1:0]   spur_q, spur_d;
  logic [15:0]         ctrl_en_data;

  always_comb begin
    ctrl_en_data           = '0;
    ctrl_en_data[CTRL_ITO] = 1'b1;
  end

  // Next-state, counter updates and the bus command for the upcoming cycle.
  // Bus outputs are registered from the next state, so the command a state
  // issues is visible on the bus while that state is current.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    spur_d  = spur_q;
    pulse_d = 1'b0;
    cmd_d   = bus_idle();

    unique case (state_q)
      IDLE:     if (enable) state_d = CFG_EN;
      CFG_EN:   state_d = WAIT_IRQ;
      WAIT_IRQ: begin
        if (irq_in)       state_d = RD_ADDR;
        else if (!enable) state_d = CFG_DIS;
      end
      RD_ADDR:  state_d = RD_DATA;
      RD_DATA: begin
        if (bus.readdata[STAT_TO]) begin
          state_d = CLR;
        end else begin
          state_d = SETTLE;
          if (spur_q != '1) spur_d = spur_q + 1'b1;
        end
      end
      CLR:      state_d = SETTLE;
      SETTLE:   state_d = WAIT_IRQ;
      CFG_DIS:  state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    unique case (state_d)
      CFG_EN:  cmd_d = bus_write(TMR_ADDR_CONTROL, ctrl_en_data);
      RD_ADDR: cmd_d = bus_read(TMR_ADDR_STATUS);
      RD_DATA: cmd_d = bus_read(TMR_ADDR_STATUS);
      CLR: begin
        cmd_d   = bus_write(TMR_ADDR_STATUS, '0);
        tick_d  = tick_q + 1'b1;
        pulse_d = 1'b1;
      end
      CFG_DIS: cmd_d = bus_write(TMR_ADDR_CONTROL, '0);
      default: cmd_d = bus_idle();
    endcase
  end

  // State, registered bus outputs and counters; reset abandons any access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cmd_q   <= bus_idle();
      tick_q  <= '0;
      pulse_q <= 1'b0;
      spur_q  <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      tick_q  <= tick_d;
      pulse_q <= pulse_d;
      spur_q  <= spur_d;
    end
  end

  // Output mapping.
  always_comb begin
    bus.chipselect = cmd_q.cs;
    bus.write_n    = cmd_q.write_n;
    bus.address    = cmd_q.addr;
    bus.writedata  = cmd_q.wdata;
    tick_count     = tick_q;
    tick_pulse     = pulse_q;
    spurious_count = spur_q;
    busy           = (state_q != IDLE) && (state_q != WAIT_IRQ);
  end

endmodule

// File: tb/tb_timer_irq_servicer.sv
// Directed, cycle-exact bench for timer_irq_servicer with a small interval
// timer slave model (status TO/RUN bits, control ITO bit, registered read).
module tb_timer_irq_servicer;
  import timer_if_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       irq_in;
  logic [3:0] tick_count;
  logic       tick_pulse;
  logic [1:0] spurious_count;
  logic       busy;

  timer_irq_servicer_if bus_if ();

  timer_irq_servicer #(.TICK_W(4), .SPUR_W(2)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .irq_in         (irq_in),
    .bus            (bus_if.master),
    .tick_count     (tick_count),
    .tick_pulse     (tick_pulse),
    .spurious_count (spurious_count),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Timer slave model.
  logic        to_flag, ito;
  logic        set_to = 1'b0;
  logic        irq_force = 1'b0;
  logic [15:0] rdata_q;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_flag <= 1'b0;
      ito     <= 1'b0;
      rdata_q <= '0;
    end else begin
      rdata_q <= '0;
      if (bus_if.chipselect && bus_if.write_n) begin
        if (bus_if.address == 3'd0) rdata_q <= {14'd0, 1'b1, to_flag};
        else if (bus_if.address == 3'd1) rdata_q <= {15'd0, ito};
      end
      if (bus_if.chipselect && !bus_if.write_n && bus_if.address == 3'd0)
        to_flag <= 1'b0;
      else if (set_to)
        to_flag <= 1'b1;
      if (bus_if.chipselect && !bus_if.write_n && bus_if.address == 3'd1)
        ito <= bus_if.writedata[0];
    end
  end

  assign bus_if.readdata = rdata_q;
  assign irq_in = (to_flag & ito) | irq_force;

  // Bus activity monitor.
  int wr_cnt = 0, rd_cnt = 0, pulse_cnt = 0;
  always @(posedge clk) begin
    if (bus_if.chipselect && !bus_if.write_n) wr_cnt++;
    if (bus_if.chipselect && bus_if.write_n)  rd_cnt++;
    if (tick_pulse) pulse_cnt++;
  end

  int n_tests = 0, n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Pulse the slave's TO flag; returns with irq_in high, FSM still in WAIT_IRQ.
  task automatic fire();
    set_to = 1'b1;
    tick();
    set_to = 1'b0;
  endtask

  task automatic do_timeout();
    fire();
    repeat (6) tick();
  endtask

  initial begin
    // Reset with enable low.
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (10) tick();
    check_eq("rst_cs",    {31'd0, bus_if.chipselect}, 32'd0);
    check_eq("rst_wn",    {31'd0, bus_if.write_n}, 32'd1);
    check_eq("rst_addr",  {29'd0, bus_if.address}, 32'd0);
    check_eq("rst_wd",    {16'd0, bus_if.writedata}, 32'd0);
    check_eq("rst_tick",  {28'd0, tick_count}, 32'd0);
    check_eq("rst_pulse", {31'd0, tick_pulse}, 32'd0);
    check_eq("rst_spur",  {30'd0, spurious_count}, 32'd0);
    check_eq("rst_busy",  {31'd0, busy}, 32'd0);
    check_eq("rst_bus_activity", wr_cnt + rd_cnt, 32'd0);

    // Enable: one control write of 0x0001.
    enable = 1'b1;
    tick();
    check_eq("en_cs",   {31'd0, bus_if.chipselect}, 32'd1);
    check_eq("en_wn",   {31'd0, bus_if.write_n}, 32'd0);
    check_eq("en_addr", {29'd0, bus_if.address}, 32'd1);
    check_eq("en_wd",   {16'd0, bus_if.writedata}, 32'h0001);
    check_eq("en_busy", {31'd0, busy}, 32'd1);
    tick();
    check_eq("wait_cs",   {31'd0, bus_if.chipselect}, 32'd0);
    check_eq("wait_busy", {31'd0, busy}, 32'd0);
    check_eq("wait_ito",  {31'd0, ito}, 32'd1);
    check_eq("en_wr_cnt", wr_cnt, 32'd1);

    // Genuine timeout service.
    fire();
    check_eq("svc_irq", {31'd0, irq_in}, 32'd1);
    tick();
    check_eq("rdaddr_cs",   {31'd0, bus_if.chipselect}, 32'd1);
    check_eq("rdaddr_wn",   {31'd0, bus_if.write_n}, 32'd1);
    check_eq("rdaddr_addr", {29'd0, bus_if.address}, 32'd0);
    check_eq("rdaddr_busy", {31'd0, busy}, 32'd1);
    tick();
    check_eq("rddata_cs",   {31'd0, bus_if.chipselect}, 32'd1);
    check_eq("rddata_addr", {29'd0, bus_if.address}, 32'd0);
    check_eq("rddata_rd",   {16'd0, bus_if.readdata}, 32'h0003);
    tick();
    check_eq("clr_cs",    {31'd0, bus_if.chipselect}, 32'd1);
    check_eq("clr_wn",    {31'd0, bus_if.write_n}, 32'd0);
    check_eq("clr_addr",  {29'd0, bus_if.address}, 32'd0);
    check_eq("clr_wd",    {16'd0, bus_if.writedata}, 32'h0000);
    check_eq("clr_pulse", {31'd0, tick_pulse}, 32'd1);
    check_eq("clr_tick",  {28'd0, tick_count}, 32'd1);
    tick();
    check_eq("settle_cs",    {31'd0, bus_if.chipselect}, 32'd0);
    check_eq("settle_irq",   {31'd0, irq_in}, 32'd0);
    check_eq("settle_pulse", {31'd0, tick_pulse}, 32'd0);
    check_eq("settle_busy",  {31'd0, busy}, 32'd1);
    tick();
    check_eq("back_busy",  {31'd0, busy}, 32'd0);
    check_eq("pulse_cnt1", pulse_cnt, 32'd1);
    check_eq("wr_cnt2",    wr_cnt, 32'd2);

    // Spurious irq held high: repeated services, saturating count, no writes.
    irq_force = 1'b1;
    tick();
    check_eq("spur_rdaddr_cs", {31'd0, bus_if.chipselect}, 32'd1);
    tick();
    check_eq("spur_rd", {16'd0, bus_if.readdata}, 32'h0002);
    tick();
    check_eq("spur_cnt1",  {30'd0, spurious_count}, 32'd1);
    check_eq("spur_cs",    {31'd0, bus_if.chipselect}, 32'd0);
    check_eq("spur_tick",  {28'd0, tick_count}, 32'd1);
    tick();
    tick();
    check_eq("spur_repeat_cs",   {31'd0, bus_if.chipselect}, 32'd1);
    check_eq("spur_repeat_addr", {29'd0, bus_if.address}, 32'd0);
    repeat (10) tick();
    irq_force = 1'b0;
    repeat (5) tick();
    check_eq("spur_sat",    {30'd0, spurious_count}, 32'd3);
    check_eq("spur_wr_cnt", wr_cnt, 32'd2);
    check_eq("spur_tick2",  {28'd0, tick_count}, 32'd1);
    check_eq("spur_busy",   {31'd0, busy}, 32'd0);

    // Tick counter wrap with TICK_W = 4.
    repeat (14) do_timeout();
    check_eq("tick_15", {28'd0, tick_count}, 32'd15);
    do_timeout();
    check_eq("tick_wrap0", {28'd0, tick_count}, 32'd0);
    repeat (2) do_timeout();
    check_eq("tick_wrap2", {28'd0, tick_count}, 32'd2);
    check_eq("pulse_cnt18", pulse_cnt, 32'd18);

    // enable drops during RD_DATA: clear completes, then disable write.
    fire();
    tick();
    tick();
    enable = 1'b0;
    tick();
    check_eq("dis_clr_addr", {29'd0, bus_if.address}, 32'd0);
    check_eq("dis_clr_wn",   {31'd0, bus_if.write_n}, 32'd0);
    check_eq("dis_clr_tick", {28'd0, tick_count}, 32'd3);
    tick();
    tick();
    check_eq("dis_wait_busy", {31'd0, busy}, 32'd0);
    check_eq("dis_wait_cs",   {31'd0, bus_if.chipselect}, 32'd0);
    tick();
    check_eq("cfgdis_cs",   {31'd0, bus_if.chipselect}, 32'd1);
    check_eq("cfgdis_wn",   {31'd0, bus_if.write_n}, 32'd0);
    check_eq("cfgdis_addr", {29'd0, bus_if.address}, 32'd1);
    check_eq("cfgdis_wd",   {16'd0, bus_if.writedata}, 32'h0000);
    check_eq("cfgdis_busy", {31'd0, busy}, 32'd1);
    tick();
    check_eq("idle_busy", {31'd0, busy}, 32'd0);
    check_eq("idle_cs",   {31'd0, bus_if.chipselect}, 32'd0);
    check_eq("idle_ito",  {31'd0, ito}, 32'd0);

    // Reset pulse during RD_ADDR: bus and counters drop immediately.
    enable = 1'b1;
    tick();
    tick();
    fire();
    tick();
    check_eq("pre_rst_cs", {31'd0, bus_if.chipselect}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("arst_cs",    {31'd0, bus_if.chipselect}, 32'd0);
    check_eq("arst_wn",    {31'd0, bus_if.write_n}, 32'd1);
    check_eq("arst_tick",  {28'd0, tick_count}, 32'd0);
    check_eq("arst_spur",  {30'd0, spurious_count}, 32'd0);
    check_eq("arst_busy",  {31'd0, busy}, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    check_eq("rearm_cs",   {31'd0, bus_if.chipselect}, 32'd1);
    check_eq("rearm_addr", {29'd0, bus_if.address}, 32'd1);
    check_eq("rearm_wd",   {16'd0, bus_if.writedata}, 32'h0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_irq_servicer.md
Name: timer_irq_servicer

Overview:
- Avalon-MM initiator that owns a 16-bit interval-timer slave: status at address 0, control at address 1, registered readdata with 1-cycle read latency, irq output.
- Enables the timer interrupt, services each irq by reading status and clearing the timeout flag, and maintains a free-running tick count for fabric logic.
- Replaces software ISR servicing, so hardware consumers get a tick without involving the Nios.

Parameters:
- TICK_W, 32, width of tick_count; wraps modulo 2^TICK_W.
- SPUR_W, 8, width of spurious_count; saturates at all-ones.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  level; 1 = interrupt servicing on, 0 = servicing off
- irq_in  in  1  timer irq, synchronous to clk
- address  out  3  Avalon address to timer
- chipselect  out  1  Avalon chipselect
- write_n  out  1  Avalon write strobe, active-low
- writedata  out  16  Avalon write data
- readdata  in  16  Avalon read data; valid in the cycle after address is presented
- tick_count  out  TICK_W  serviced timeouts
- tick_pulse  out  1  one-cycle pulse per serviced timeout
- spurious_count  out  SPUR_W  irqs whose status read showed bit0 = 0
- busy  out  1  1 in every state except IDLE and WAIT_IRQ

Behaviour:
- Reset (async assert; sync release on next clk edge):
  - state = IDLE, chipselect = 0, write_n = 1, address = 0, writedata = 0.
  - tick_count = 0, tick_pulse = 0, spurious_count = 0, busy = 0.
- Idle bus: whenever no access is issued, chipselect = 0, write_n = 1, address = 0, writedata = 0.
- All bus outputs are registered. Each access lasts exactly one cycle; the slave has no waitrequest.
- FSM:
  - IDLE: if enable = 1, go to CFG_EN.
  - CFG_EN: write address 1, data 0x0001; go to WAIT_IRQ.
  - WAIT_IRQ:
    - irq_in = 1 → RD_ADDR. irq has priority over enable = 0.
    - else if enable = 0 → CFG_DIS.
  - RD_ADDR: chipselect = 1, write_n = 1, address = 0; go to RD_DATA.
  - RD_DATA: hold address = 0 and chipselect = 1; sample readdata at the end of this cycle.
    - readdata[0] = 1 → CLR.
    - readdata[0] = 0 → spurious_count += 1 (saturating), then SETTLE.
  - CLR: write address 0, data 0x0000. Same cycle: tick_count += 1 (wrapping) and tick_pulse = 1. Go to SETTLE.
  - SETTLE: one dead cycle so the slave's irq has deasserted; go to WAIT_IRQ. irq_in is ignored here.
  - CFG_DIS: write address 1, data 0x0000; go to IDLE.
- enable falling mid-service (RD_ADDR..SETTLE): the service completes first, then WAIT_IRQ routes to CFG_DIS.
- enable re-rising while in CFG_DIS: finish the disable write, go to IDLE, then CFG_EN next cycle.
- Spurious read: no clear write is issued. If irq_in is still 1 after SETTLE, the service is repeated. This is required behaviour; no lockout.
- tick_count wraps from 2^TICK_W−1 to 0 with no flag. spurious_count holds at 2^SPUR_W−1.
- Reset mid-operation (any state): immediate return to reset values. Any partial bus access is abandoned; chipselect drops asynchronously.
- Service latency: irq_in sampled high at edge E → RD_ADDR in cycle E+1 → CLR write in cycle E+3 → back in WAIT_IRQ at cycle E+5.

Decomposition:
- Shared package timer_if_pkg:
  - Address constants TMR_ADDR_STATUS = 3'd0, TMR_ADDR_CONTROL = 3'd1.
  - Status bit index STAT_TO = 0; control bit index CTRL_ITO = 0.
  - FSM state enum (IDLE, CFG_EN, WAIT_IRQ, RD_ADDR, RD_DATA, CLR, SETTLE, CFG_DIS).
- Single module, no sub-module: the FSM and counters are small and tightly coupled.

Test Plan:
- Reset with enable = 0, run 10 cycles → all outputs at reset values, no chipselect activity, busy = 0.
- enable 0→1 → exactly one write, address 1, writedata 0x0001; then WAIT_IRQ idle bus, busy = 0.
- Slave model raises irq, returns readdata 0x0003 → read at address 0, then write address 0 data 0x0000 two cycles later; tick_count = 1, one tick_pulse; the model's irq clears.
- irq_in = 1 with readdata 0x0002 → spurious_count = 1, no write issued, tick_count unchanged; irq held high → service repeats.
- TICK_W = 4, 17 timeouts → tick_count = 1 after wrapping through 0.
- enable = 0 while in RD_DATA → clear write completes, then write address 1 data 0x0000, then IDLE. Separately, reset_n pulse during RD_ADDR → chipselect = 0 within the same cycle, counters = 0.
